imem_responder: RTL
===================

// Module: imem_responder
// PURPOSE
//  Instruction-memory responder: the memory end of the core's fetch interface. The core presents a PC,
//  this block returns the 32-bit instruction word. One request outstanding, valid/ready handshakes on both
//  channels, programmable access latency, error flag for misaligned/out-of-range PCs, preload port for benches.
// PARAMETERS
//  DEPTH      1024           number of 32-bit words in the array (power of 2, >=2)
//  BASE_ADDR  32'h8000_0000  byte address of word 0
//  LATENCY    1              cycles from request accept edge to rsp_valid high (1..15)
// PORTS
//  clk        in   1   clock, all state on rising edge
//  rst        in   1   asynchronous, active-low reset
//  req_valid  in   1   core presents a fetch address
//  req_ready  out  1   responder can accept a request
//  req_addr   in   32  fetch byte address (PC)
//  rsp_valid  out  1   rsp_inst/rsp_err valid
//  rsp_ready  in   1   core accepts the response
//  rsp_inst   out  32  instruction word
//  rsp_err    out  1   1 = misaligned or out-of-range fetch
//  load_en    in   1   preload write strobe
//  load_addr  in   log2(DEPTH)  preload word index
//  load_data  in   32  preload word
//  fetch_cnt  out  32  completed responses (wraps)
//  err_cnt    out  16  completed responses with rsp_err=1 (saturates at 16'hFFFF)
// BEHAVIOUR
//  - Reset (rst=0, async): state IDLE, req_ready=1, rsp_valid=0, rsp_inst=0, rsp_err=0, counters=0.
//    Array contents NOT reset. Reset mid-transaction drops it; no response is ever issued for it.
//  - FSM IDLE -> (WAIT) -> RESP -> IDLE.
//    IDLE: req_ready=1. Accept on req_valid&req_ready edge: latch word/error, go WAIT if LATENCY>1 else RESP.
//    WAIT: req_ready=0; 4-bit down-counter loaded with LATENCY-2 at accept; go RESP when counter==0.
//    RESP: rsp_valid=1, req_ready=0; outputs held stable until rsp_valid&rsp_ready edge, then IDLE.
//  - rsp_valid first high exactly LATENCY cycles after accept edge. Min period per fetch = LATENCY+1 cycles
//    (RESP->IDLE costs one cycle; no accept in the RESP handshake cycle).
//  - Address check at accept: off = req_addr - BASE_ADDR (32-bit wrap).
//    err if req_addr[1:0]!=0 or off >= DEPTH*4 (covers req_addr<BASE_ADDR via wrap).
//    err: rsp_inst=32'h0, rsp_err=1. else rsp_inst=mem[off[log2(DEPTH)+1:2]], rsp_err=0.
//  - Data captured at the accept edge: later load_en writes do not alter a pending response.
//    Load and accept to same word in same cycle -> response returns OLD word; array holds new word after edge.
//  - load_en is legal in any state, independent of the fetch FSM.
//  - fetch_cnt += 1 on each response handshake; err_cnt += 1 on handshake with rsp_err=1.
//  - req_addr/req_valid ignored outside IDLE; rsp_ready ignored outside RESP.
// TESTING
//  1. Preload mem[0]=32'h0000_0413, LATENCY=1; req 32'h8000_0000 with rsp_ready=1 -> rsp_valid next cycle,
//     rsp_inst=32'h0000_0413, rsp_err=0, fetch_cnt=1, req_ready back to 1 one cycle after handshake.
//  2. LATENCY=3; accept at edge T -> rsp_valid low at T+1,T+2, high at T+3; rsp_ready held 0 for 5 cycles
//     -> rsp_inst/rsp_valid stable, req_ready=0 throughout.
//  3. req 32'h8000_0002 -> rsp_err=1, rsp_inst=0; req 32'h7FFF_FFFC and 32'h8000_1000 (DEPTH=1024)
//     -> both rsp_err=1; err_cnt=3.
//  4. mem[5]=32'hAAAA_AAAA; same cycle load_en to word 5 with 32'hBBBB_BBBB and accept of 32'h8000_0014
//     -> response 32'hAAAA_AAAA; next fetch of same addr -> 32'hBBBB_BBBB.
//  5. Assert rst low while in WAIT (LATENCY=4) -> immediately rsp_valid=0, req_ready=1, counters=0;
//     after release no stale response appears; array preserves preloaded data.
//  6. 100 back-to-back fetches, rsp_ready=1, LATENCY=1 -> one response every 2 cycles, fetch_cnt=100, in order.

Source files
------------

// File: rtl/imem_responder.sv
// Instruction-memory responder: accepts one fetch address at a time and returns the
// addressed 32-bit word after a fixed access latency, flagging misaligned/out-of-range PCs.
module imem_responder #(
    parameter int          DEPTH     = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
    parameter int          LATENCY   = 1
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     req_valid_i,
    output logic                     req_ready_o,
    input  logic [31:0]              req_addr_i,
    output logic                     rsp_valid_o,
    input  logic                     rsp_ready_i,
    output logic [31:0]              rsp_inst_o,
    output logic                     rsp_err_o,
    input  logic                     load_en_i,
    input  logic [$clog2(DEPTH)-1:0] load_addr_i,
    input  logic [31:0]              load_data_i,
    output logic [31:0]              fetch_cnt_o,
    output logic [15:0]              err_cnt_o
);

    localparam int          AW        = $clog2(DEPTH);
    localparam logic [31:0] SPAN      = 32'(DEPTH * 4);
    localparam logic [3:0]  WAIT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

    logic [31:0] mem [DEPTH];

    state_e      state_q;
    logic [3:0]  cnt_q;
    logic        req_ready_q;
    logic        rsp_valid_q;
    logic        rsp_err_q;
    logic [31:0] rsp_inst_q;
    logic [31:0] fetch_cnt_q;
    logic [15:0] err_cnt_q;

    logic [31:0] off;
    logic        addr_err;
    logic [31:0] mem_word;

    // Addresses below BASE_ADDR wrap to huge offsets, so one compare covers both bounds.
    assign off      = req_addr_i - BASE_ADDR;
    assign addr_err = (req_addr_i[1:0] != 2'b00) || (off >= SPAN);
    assign mem_word = mem[off[AW+1:2]];

    always_ff @(posedge clk_i) begin
        if (load_en_i) begin
            mem[load_addr_i] <= load_data_i;
        end
    end

    // The word is captured at the accept edge, so it sees the array before any same-cycle load.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_inst_q  <= 32'h0;
            fetch_cnt_q <= 32'h0;
            err_cnt_q   <= 16'h0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid_i) begin
                        req_ready_q <= 1'b0;
                        rsp_err_q   <= addr_err;
                        rsp_inst_q  <= addr_err ? 32'h0 : mem_word;
                        if (LATENCY > 1) begin
                            state_q <= WAIT;
                            cnt_q   <= WAIT_INIT;
                        end else begin
                            state_q     <= RESP;
                            rsp_valid_q <= 1'b1;
                        end
                    end
                end
                WAIT: begin
                    if (cnt_q == 4'd0) begin
                        state_q     <= RESP;
                        rsp_valid_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        state_q     <= IDLE;
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        fetch_cnt_q <= fetch_cnt_q + 32'd1;
                        if (rsp_err_q && (err_cnt_q != 16'hFFFF)) begin
                            err_cnt_q <= err_cnt_q + 16'd1;
                        end
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    req_ready_q <= 1'b1;
                    rsp_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready_o = req_ready_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_inst_o  = rsp_inst_q;
    assign rsp_err_o   = rsp_err_q;
    assign fetch_cnt_o = fetch_cnt_q;
    assign err_cnt_o   = err_cnt_q;

endmodule
